// File: rtl/logic_slice_seq_if.sv
// Operand/result handshake bundle for logic_slice_seq.
// The master side is the operand source plus result consumer; the slave side is the unit.
interface logic_slice_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, zero, busy
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, zero, busy
    );
endinterface

// File: rtl/logic_slice_seq.sv
// Sequential bitwise AND/OR/XOR/NOR unit that streams latched operands through a
// 4-bit logic slice, least-significant nibble first, and assembles the full result.
//
//   state  | meaning
//   IDLE   | ready for operands; accept latches a/b/op and clears result
//   RUN    | one nibble per cycle written into result
//   DONE   | result held with out_valid until the consumer takes it
module logic_slice_seq #(
    parameter int WIDTH = 16
) (
    input logic              clk,
    input logic              rst,
    logic_slice_seq_if.slave bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
            $error("logic_slice_seq: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] res_q;
    logic [IW-1:0]    idx;
    logic             last;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       s_nib;

    assign last  = (idx == IW'(NSLICE - 1));
    assign a_nib = a_q[idx*4 +: 4];
    assign b_nib = b_q[idx*4 +: 4];

    always_comb begin
        case (op_q)
            2'b00:   s_nib = a_nib & b_nib;
            2'b01:   s_nib = a_nib | b_nib;
            2'b10:   s_nib = a_nib ^ b_nib;
            default: s_nib = ~(a_nib | b_nib);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.in_valid) state_nx = S_RUN;
            S_RUN:   if (last) state_nx = S_DONE;
            S_DONE:  if (bus.out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == S_IDLE);
        bus.out_valid = (state == S_DONE);
        bus.busy      = (state == S_RUN) || (state == S_DONE);
        bus.zero      = (state == S_DONE) && (res_q == '0);
        bus.result    = res_q;
    end

    // Index holds at the last slice rather than wrapping; the next accept clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= 2'b00;
            res_q <= '0;
            idx   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        op_q  <= bus.op;
                        res_q <= '0;
                        idx   <= '0;
                    end
                end
                S_RUN: begin
                    res_q[idx*4 +: 4] <= s_nib;
                    if (!last) begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_logic_slice_seq.sv
// Directed bench for logic_slice_seq: 16-bit and 4-bit instances, queue scoreboard.
module tb_logic_slice_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   acc_cyc = 0;
    int   prev_acc = 0;
    int   lat = 0;
    logic [15:0] exp16;
    logic [15:0] tmp16;
    logic [3:0]  exp4;
    logic [15:0] sb16[$];
    logic [3:0]  sb4[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic_slice_seq_if #(.WIDTH(16)) bus16();
    logic_slice_seq_if #(.WIDTH(4))  bus4();

    logic_slice_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
    logic_slice_seq #(.WIDTH(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4));

    function automatic logic [15:0] model(input logic [15:0] av, input logic [15:0] bv,
                                          input logic [1:0] opv);
        case (opv)
            2'b00:   return av & bv;
            2'b01:   return av | bv;
            2'b10:   return av ^ bv;
            default: return ~(av | bv);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept16(input logic [15:0] av, input logic [15:0] bv, input logic [1:0] opv);
        int n;
        n = 0;
        @(negedge clk);
        while (bus16.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_accept", 32'(bus16.in_ready), 32'd1);
        bus16.in_valid = 1'b1;
        bus16.a  = av;
        bus16.b  = bv;
        bus16.op = opv;
        sb16.push_back(model(av, bv, opv));
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus16.in_valid = 1'b0;
    endtask

    task automatic wait_valid16();
        lat = 0;
        while (bus16.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Expects out_ready already high: checks the result, then the handshake edge.
    task automatic finish16(input string tag);
        if (sb16.size() > 0) exp16 = sb16.pop_front();
        else exp16 = 'x;
        chk({tag, "_out_valid"}, 32'(bus16.out_valid), 32'd1);
        chk({tag, "_result"}, 32'(bus16.result), 32'(exp16));
        chk({tag, "_zero"}, 32'(bus16.zero), 32'(exp16 == 16'h0000));
        @(posedge clk);
        #1;
        chk({tag, "_in_ready_after"}, 32'(bus16.in_ready), 32'd1);
        chk({tag, "_out_valid_after"}, 32'(bus16.out_valid), 32'd0);
    endtask

    initial begin
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.op = 2'b00; bus16.out_ready = 1'b0;
        bus4.in_valid  = 1'b0; bus4.a  = '0; bus4.b  = '0; bus4.op  = 2'b00; bus4.out_ready  = 1'b0;

        #12;
        chk("rst_in_ready", 32'(bus16.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus16.out_valid), 32'd0);
        chk("rst_result", 32'(bus16.result), 32'd0);
        chk("rst_zero", 32'(bus16.zero), 32'd0);
        chk("rst_busy", 32'(bus16.busy), 32'd0);
        chk("rst_in_ready4", 32'(bus4.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // OR with latency and busy checks
        bus16.out_ready = 1'b1;
        accept16(16'h1234, 16'h8421, 2'b01);
        chk("or_in_ready_run", 32'(bus16.in_ready), 32'd0);
        chk("or_busy_run", 32'(bus16.busy), 32'd1);
        wait_valid16();
        chk("or_latency", 32'(lat), 32'd4);
        finish16("or");

        // AND, XOR, NOR back to back
        accept16(16'hF0F0, 16'h0FF0, 2'b00);
        prev_acc = acc_cyc;
        wait_valid16();
        chk("and_latency", 32'(lat), 32'd4);
        finish16("and");
        accept16(16'hF0F0, 16'h0FF0, 2'b10);
        chk("xor_interval", 32'(acc_cyc - prev_acc), 32'd6);
        prev_acc = acc_cyc;
        wait_valid16();
        finish16("xor");
        accept16(16'hFFFF, 16'h0000, 2'b11);
        chk("nor_interval", 32'(acc_cyc - prev_acc), 32'd6);
        wait_valid16();
        finish16("nor");

        // Backpressure with an ignored in_valid pulse
        bus16.out_ready = 1'b0;
        accept16(16'hA5A5, 16'h0F0F, 2'b10);
        wait_valid16();
        chk("bp_latency", 32'(lat), 32'd4);
        exp16 = sb16.pop_front();
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(bus16.out_valid), 32'd1);
            chk("bp_result", 32'(bus16.result), 32'(exp16));
            chk("bp_in_ready", 32'(bus16.in_ready), 32'd0);
            if (i == 1) begin
                bus16.in_valid = 1'b1;
                bus16.a = 16'hFFFF;
                bus16.b = 16'hFFFF;
                bus16.op = 2'b00;
            end
            if (i == 2) bus16.in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        bus16.out_ready = 1'b1;
        chk("bp_result_release", 32'(bus16.result), 32'(exp16));
        @(posedge clk);
        #1;
        chk("bp_in_ready_after", 32'(bus16.in_ready), 32'd1);
        chk("bp_out_valid_after", 32'(bus16.out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("bp_no_queue_busy", 32'(bus16.busy), 32'd0);

        // Operand change during RUN
        accept16(16'h1234, 16'h8421, 2'b01);
        bus16.a  = 16'h0000;
        bus16.op = 2'b00;
        wait_valid16();
        chk("chg_latency", 32'(lat), 32'd4);
        finish16("chg");

        // Asynchronous reset after two slices
        accept16(16'h1234, 16'h8421, 2'b01);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        tmp16 = sb16[sb16.size()-1];
        chk("ar_partial", 32'(bus16.result), 32'(tmp16 & 16'h00FF));
        #2;
        rst = 1'b1;
        #1;
        chk("ar_result", 32'(bus16.result), 32'd0);
        chk("ar_out_valid", 32'(bus16.out_valid), 32'd0);
        chk("ar_in_ready", 32'(bus16.in_ready), 32'd1);
        chk("ar_busy", 32'(bus16.busy), 32'd0);
        void'(sb16.pop_back());
        rst = 1'b0;
        accept16(16'h0F0F, 16'hF000, 2'b01);
        wait_valid16();
        chk("ar_next_latency", 32'(lat), 32'd4);
        finish16("ar_next");

        // WIDTH=4 instance
        bus4.out_ready = 1'b1;
        @(negedge clk);
        chk("w4_in_ready", 32'(bus4.in_ready), 32'd1);
        bus4.in_valid = 1'b1; bus4.a = 4'b1001; bus4.b = 4'b0101; bus4.op = 2'b01;
        tmp16 = model(16'h0009, 16'h0005, 2'b01);
        sb4.push_back(tmp16[3:0]);
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        lat = 0;
        while (bus4.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("w4_latency", 32'(lat), 32'd1);
        exp4 = sb4.pop_front();
        chk("w4_result", 32'(bus4.result), 32'(exp4));
        @(posedge clk);
        #1;
        chk("w4_in_ready_after", 32'(bus4.in_ready), 32'd1);
        @(negedge clk);
        bus4.in_valid = 1'b1; bus4.a = 4'b0011; bus4.b = 4'b1100; bus4.op = 2'b01;
        tmp16 = model(16'h0003, 16'h000C, 2'b01);
        sb4.push_back(tmp16[3:0]);
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        lat = 0;
        while (bus4.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("w4b_latency", 32'(lat), 32'd1);
        exp4 = sb4.pop_front();
        chk("w4b_result", 32'(bus4.result), 32'(exp4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/logic_slice_seq.md
# logic_slice_seq

Multi-cycle bitwise logic unit that computes AND/OR/XOR/NOR on WIDTH-bit operands by streaming them through a 4-bit logic slice, least-significant nibble first. It is the sequential stage that feeds 4-bit slices into the slice logic and collects the slice outputs into a full-width result. It uses a valid/ready handshake on both input and output, so it can sit between an operand source and a result consumer in the BinaryLogic datapath.

## Interface
- WIDTH, 16, operand/result width. Must be a multiple of 4 and at least 4; any other value is an elaboration error.
- NSLICE (localparam) = WIDTH/4, the number of slice steps.

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand request valid
- in_ready  output  1  unit can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NOR
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  assembled result
- zero  output  1  result == 0; valid only while out_valid = 1
- busy  output  1  high in RUN or DONE

## Operation
- FSM states and behaviour:
  - IDLE: in_ready = 1. When in_valid = 1, latch a, b and op. Clear result and the slice index to 0, then go to RUN.
  - RUN: in_ready = 0. Each cycle, compute slice i = op(a[4i+3:4i], b[4i+3:4i]) and write it to result[4i+3:4i]. Then i <= i+1. When the slice with i = NSLICE-1 is written, go to DONE.
  - DONE: out_valid = 1. When out_ready = 1, the transfer completes at that edge and the FSM goes to IDLE. Otherwise it holds.
- NOR is computed per slice as ~(a|b) and is 4 bits wide. There is no carry or interaction between slices.
- Latched operands are the only operands used. Changes on a/b/op after the accept edge have no effect.
- in_valid is ignored in RUN and DONE; it does not queue.
- zero is computed from the final result and is forced to 0 outside DONE.
- Reset value of every output:
  - in_ready = 1 (IDLE)
  - out_valid = 0
  - result = 0
  - zero = 0
  - busy = 0
  - Internal slice index = 0.
- Reset asserted mid-operation (RUN or DONE): all state and outputs take their reset values immediately (asynchronously). The operation in progress is discarded. After reset deasserts, the next accepted op runs normally.
- Slice index width is clog2(NSLICE), with a minimum of 1 bit. It never wraps, because RUN exits at NSLICE-1.

## Timing
- Accept edge E0: in_valid & in_ready high at a rising edge.
- Slices are written at edges E1 through E_NSLICE. out_valid rises after E_NSLICE.
- Latency from the accept edge to out_valid is NSLICE cycles (4 cycles for WIDTH = 16; 1 cycle for WIDTH = 4).
- Output handshake completes at the first edge with out_valid & out_ready. in_ready rises after that edge.
- Minimum issue interval is NSLICE+2 cycles: one accept cycle, NSLICE RUN cycles, and one DONE cycle with out_ready held high.
- result and zero are stable for the whole time out_valid is high, including under backpressure.
- Combinational paths:
  - Outputs are registered or decoded from FSM state only.
  - in_ready, out_valid and busy decode directly from state.
  - There are no combinational paths from input to output.

## Test plan
- OR, WIDTH=16: a=16'h1234, b=16'h8421, op=01. Required: out_valid exactly 4 cycles after accept; result=16'h9635; zero=0; in_ready=0 and busy=1 during the operation.
- AND, XOR and NOR sequence, out_ready held high. Required results:
  - a=16'hF0F0, b=16'h0FF0, op=00 gives 16'h00F0.
  - op=10 on the same operands gives 16'hFF00.
  - a=16'hFFFF, b=16'h0000, op=11 gives 16'h0000 with zero=1.
  - Each operation completes in 6 cycles accept-to-accept.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises. Required: result and out_valid hold; in_ready=0; an in_valid pulse with new operands is ignored. When out_ready=1, the transfer completes and in_ready=1 on the next cycle.
- Operand change mid-RUN: after accepting a=16'h1234, b=16'h8421, op=01, drive a=16'h0000 and op=00 during RUN. Required: result is still 16'h9635.
- Asynchronous reset after 2 slices of RUN. Required: result=0, out_valid=0, in_ready=1 and busy=0 immediately, before the next clock edge. A following OR of 16'h0F0F|16'hF000 gives 16'hFF0F.
- WIDTH=4 instance: a=4'b1001, b=4'b0101, op=01. Required: out_valid 1 cycle after accept, result=4'b1101. Then a=4'b0011, b=4'b1100, op=01 gives 4'b1111.
